// File: rtl/ru_pkg.sv
// ru_pkg: mode bit positions, the log2(e) scale constant and the saturating
// fixed-point helpers shared by the ru_pipe_v2 lanes.
// All helpers work on a 64-bit signed scratch type and take the word and
// fraction widths as arguments, so one package serves any DATA_W up to 32.
package ru_pkg;

    // Bit positions inside the per-beat 2-bit mode field.
    localparam int MODE_SUB_DIRECT = 0;  // 1: subtract in0 as-is, 0: subtract log2(in0)
    localparam int MODE_MULT_LOG2E = 1;  // 1: scale by log2(e), 0: scale by 1.0

    // Depth of the datapath; the valid pipeline at the top matches it.
    localparam int PIPE_STAGES = 6;

    localparam int CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    localparam calc_t C_ONE  = calc_t'(1);
    localparam calc_t C_ZERO = calc_t'(0);

    // floor(log2(e) * 2^32); narrower formats are obtained by shifting down.
    localparam calc_t LOG2E_Q32 = calc_t'(64'h0000_0001_7154_7652);

    // floor(log2(e) * 2^frac_w), e.g. 0x05C5 for frac_w = 10.
    function automatic calc_t log2e_k(input int frac_w);
        return LOG2E_Q32 >>> (32 - frac_w);
    endfunction

    // Clamp v into the range of a w-bit two's complement word.
    function automatic calc_t sat_s(input calc_t v, input int w);
        calc_t hi;
        calc_t lo;
        hi = (C_ONE <<< (w - 1)) - C_ONE;
        lo = C_ZERO - (C_ONE <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Mitchell log2: the leading-one index gives the integer part, the bits
    // below it (left-aligned, truncated) give the fraction. Non-positive
    // inputs map to the most negative word.
    function automatic calc_t mitchell_log2(input calc_t v, input int frac_w, input int data_w);
        int    p;
        calc_t below;
        calc_t frac;
        if (v <= C_ZERO) return C_ZERO - (C_ONE <<< (data_w - 1));
        p = 0;
        for (int i = 0; i < CALC_W - 1; i++) begin
            if (v[i]) p = i;
        end
        below = v & ((C_ONE <<< p) - C_ONE);
        if (p >= frac_w) frac = below >>> (p - frac_w);
        else             frac = below <<< (frac_w - p);
        return sat_s((calc_t'(p - frac_w) <<< frac_w) + frac, data_w);
    endfunction

    // pow2 of a fixed-point value: mantissa 1.f shifted by the floor of x.
    // Large positive exponents saturate, large negative ones underflow to 0.
    function automatic calc_t pow2_q(input calc_t x, input int frac_w, input int data_w);
        calc_t i_part;
        calc_t m;
        calc_t hi;
        hi     = (C_ONE <<< (data_w - 1)) - C_ONE;
        i_part = x >>> frac_w;
        m      = (C_ONE <<< frac_w) + (x & ((C_ONE <<< frac_w) - C_ONE));
        if (i_part >= C_ZERO) begin
            if (i_part >= calc_t'(data_w)) return hi;
            m = m <<< i_part;
            return (m > hi) ? hi : m;
        end
        if ((C_ZERO - i_part) >= calc_t'(CALC_W - 1)) return C_ZERO;
        return m >>> (C_ZERO - i_part);
    endfunction

endpackage

// File: rtl/ru_lane.sv
// ru_lane: one lane of the reduction datapath, six register stages that all
// move together on i_en:
//   1 capture, 2 Mitchell log2, 3 saturating subtract, 4 scale multiply,
//   5 shift back to FRAC_W (saturated), 6 pow2.
// Build option: define RU_ROUND_EN to round half-up in stage 5 instead of
// truncating.
module ru_lane #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_in0,
    input  logic [DATA_W-1:0] i_in1,
    output logic [DATA_W-1:0] o_x,
    output logic [DATA_W-1:0] o_pow2
);
    import ru_pkg::*;

    localparam int PW = 2 * DATA_W;
    localparam logic signed [DATA_W-1:0] K_LOG2E = DATA_W'(log2e_k(FRAC_W));
    localparam logic signed [DATA_W-1:0] K_ONE   = DATA_W'(C_ONE <<< FRAC_W);

    logic signed [DATA_W-1:0] s1_in0, s1_in1;
    logic [1:0]               s1_mode;
    logic signed [DATA_W-1:0] s2_in0, s2_log, s2_in1;
    logic [1:0]               s2_mode;
    logic signed [DATA_W-1:0] s3_diff;
    logic                     s3_klog;
    logic signed [PW-1:0]     s4_prod;
    logic signed [DATA_W-1:0] s5_x;
    logic signed [DATA_W-1:0] s6_x, s6_p;

    logic signed [DATA_W-1:0] s2_sub;
    logic signed [DATA_W-1:0] k_sel;
    calc_t                    s4_adj;

    assign s2_sub = s2_mode[MODE_SUB_DIRECT] ? s2_in0 : s2_log;
    assign k_sel  = s3_klog ? K_LOG2E : K_ONE;

    // Stage 5 pre-shift adjustment: optional half-LSB bias for rounding.
    always_comb begin
        s4_adj = calc_t'(s4_prod);
`ifdef RU_ROUND_EN
        s4_adj = calc_t'(s4_prod) + (C_ONE <<< (FRAC_W - 1));
`endif
    end

    // Datapath registers; the whole lane holds while i_en is low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_in0  <= '0;
            s1_in1  <= '0;
            s1_mode <= '0;
            s2_in0  <= '0;
            s2_log  <= '0;
            s2_in1  <= '0;
            s2_mode <= '0;
            s3_diff <= '0;
            s3_klog <= 1'b0;
            s4_prod <= '0;
            s5_x    <= '0;
            s6_x    <= '0;
            s6_p    <= '0;
        end else if (i_en) begin
            s1_in0  <= i_in0;
            s1_in1  <= i_in1;
            s1_mode <= i_mode;
            s2_in0  <= s1_in0;
            s2_log  <= DATA_W'(mitchell_log2(calc_t'(s1_in0), FRAC_W, DATA_W));
            s2_in1  <= s1_in1;
            s2_mode <= s1_mode;
            s3_diff <= DATA_W'(sat_s(calc_t'(s2_in1) - calc_t'(s2_sub), DATA_W));
            s3_klog <= s2_mode[MODE_MULT_LOG2E];
            s4_prod <= PW'(s3_diff) * PW'(k_sel);
            s5_x    <= DATA_W'(sat_s(s4_adj >>> FRAC_W, DATA_W));
            s6_x    <= s5_x;
            s6_p    <= DATA_W'(pow2_q(calc_t'(s5_x), FRAC_W, DATA_W));
        end
    end

    assign o_x    = s6_x;
    assign o_pow2 = s6_p;

endmodule

// File: rtl/ru_pipe_v2.sv
// ru_pipe_v2: multi-lane softmax reduction step. Each lane computes
// x = (in1 - f(in0)) * K and pow2(x), with f and K chosen per beat by i_mode.
// The top owns the valid pipeline and the handshake; lanes carry data only.
// Build option: RU_ROUND_EN selects round-half-up in the lanes' final shift.
//
// Handshake: a beat transfers on the input side when i_valid & o_ready and on
// the output side when o_valid & i_ready. The pipeline advances as a whole
// whenever the output register is empty or being drained
// (adv = i_ready | ~o_valid), and o_ready is exactly adv. Bubbles are not
// squeezed out, and outputs hold steady while o_valid & ~i_ready.
module ru_pipe_v2 #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 10,
    parameter int LANES  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [1:0]              i_mode,
    input  logic [LANES*DATA_W-1:0] i_in0,
    input  logic [LANES*DATA_W-1:0] i_in1,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [LANES*DATA_W-1:0] o_out0,
    output logic [LANES*DATA_W-1:0] o_out1
);
    import ru_pkg::*;

    logic                   adv;
    logic [PIPE_STAGES-1:0] vld;

    assign adv     = i_ready | ~o_valid;
    assign o_ready = adv;
    assign o_valid = vld[PIPE_STAGES-1];

    // Valid bit per stage, shifted in lockstep with the lane datapaths.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld <= '0;
        end else if (adv) begin
            vld <= {vld[PIPE_STAGES-2:0], i_valid};
        end
    end

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        ru_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_en   (adv),
            .i_mode (i_mode),
            .i_in0  (i_in0[n*DATA_W +: DATA_W]),
            .i_in1  (i_in1[n*DATA_W +: DATA_W]),
            .o_x    (o_out0[n*DATA_W +: DATA_W]),
            .o_pow2 (o_out1[n*DATA_W +: DATA_W])
        );
    end

endmodule
